// File: rtl/hamming_dec_12_8.sv
`timescale 1ns/1ps
// Two-stage Hamming(12,8) single-error-correcting decoder with a valid/ready stream,
// per-word status and saturating corrected/uncorrectable word counters.
module hamming_dec_12_8 #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [11:0]          in_codeword,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic [3:0]           out_syndrome,
    output logic                 out_corrected,
    output logic                 out_uncorrectable,
    input  logic                 clear_counts,
    output logic [CNT_WIDTH-1:0] corr_count,
    output logic [CNT_WIDTH-1:0] uncorr_count
);

    function automatic logic [3:0] parity_bits(input logic [7:0] d);
        return {d[4] ^ d[5] ^ d[6] ^ d[7],
                d[1] ^ d[2] ^ d[3] ^ d[7],
                d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6],
                d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6]};
    endfunction

    // Check-bit syndromes (1,2,4,8) and unmappable ones (13..15) leave the data untouched.
    function automatic logic [7:0] flip_mask(input logic [3:0] s);
        logic [7:0] m;
        m = 8'h00;
        case (s)
            4'd3:    m = 8'h01;
            4'd5:    m = 8'h02;
            4'd6:    m = 8'h04;
            4'd7:    m = 8'h08;
            4'd9:    m = 8'h10;
            4'd10:   m = 8'h20;
            4'd11:   m = 8'h40;
            4'd12:   m = 8'h80;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    function automatic logic is_uncorr(input logic [3:0] s);
        return s >= 4'd13;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + CNT_WIDTH'(1);
    endfunction

    logic                 rdy_q;
    logic                 vld_p1;
    logic [7:0]           data_p1;
    logic [3:0]           syn_p1;
    logic                 vld_p2;
    logic [7:0]           data_p2;
    logic [3:0]           syn_p2;
    logic                 corr_p2;
    logic                 uncorr_p2;
    logic [CNT_WIDTH-1:0] corr_cnt;
    logic [CNT_WIDTH-1:0] uncorr_cnt;

    logic adv1, adv2, acc, load2;
    logic dec_corr, dec_uncorr;

    // rdy_q keeps in_ready low until the first clock edge after reset release.
    assign adv2     = !vld_p2 || out_ready;
    assign adv1     = !vld_p1 || adv2;
    assign in_ready = rdy_q && adv1;
    assign acc      = in_valid && in_ready;
    assign load2    = vld_p1 && adv2;

    assign dec_uncorr = is_uncorr(syn_p1);
    assign dec_corr   = (syn_p1 != 4'd0) && !dec_uncorr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    // Stage S1: capture received data byte and syndrome
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            syn_p1  <= '0;
        end else begin
            if (adv1) vld_p1 <= acc;
            if (acc) begin
                data_p1 <= in_codeword[7:0];
                syn_p1  <= parity_bits(in_codeword[7:0]) ^ in_codeword[11:8];
            end
        end
    end

    // Stage S2: corrected data, status and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            syn_p2    <= '0;
            corr_p2   <= 1'b0;
            uncorr_p2 <= 1'b0;
        end else begin
            if (adv2) vld_p2 <= vld_p1;
            if (load2) begin
                data_p2   <= data_p1 ^ flip_mask(syn_p1);
                syn_p2    <= syn_p1;
                corr_p2   <= dec_corr;
                uncorr_p2 <= dec_uncorr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (clear_counts) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (load2 && dec_corr)   corr_cnt   <= sat_inc(corr_cnt);
            if (load2 && dec_uncorr) uncorr_cnt <= sat_inc(uncorr_cnt);
        end
    end

    assign out_valid         = vld_p2;
    assign out_data          = data_p2;
    assign out_syndrome      = syn_p2;
    assign out_corrected     = corr_p2;
    assign out_uncorrectable = uncorr_p2;
    assign corr_count        = corr_cnt;
    assign uncorr_count      = uncorr_cnt;

endmodule

// File: tb/tb_hamming_dec_12_8.sv
`timescale 1ns/1ps
// Directed bench for hamming_dec_12_8: a 16-bit-counter instance for function and a
// 2-bit-counter instance, driven identically, for counter saturation.
module tb_hamming_dec_12_8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_codeword;
    logic        out_ready;
    logic        clear_counts;

    logic        in_ready, out_valid, out_corrected, out_uncorrectable;
    logic [7:0]  out_data;
    logic [3:0]  out_syndrome;
    logic [15:0] corr_count, uncorr_count;

    logic        s_in_ready, s_out_valid, s_out_corrected, s_out_uncorrectable;
    logic [7:0]  s_out_data;
    logic [3:0]  s_out_syndrome;
    logic [1:0]  s_corr_count, s_uncorr_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hamming_dec_12_8 #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_codeword(in_codeword),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_corrected(out_corrected),
        .out_uncorrectable(out_uncorrectable), .clear_counts(clear_counts),
        .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    hamming_dec_12_8 #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_codeword(in_codeword),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_syndrome(s_out_syndrome), .out_corrected(s_out_corrected),
        .out_uncorrectable(s_out_uncorrectable), .clear_counts(clear_counts),
        .corr_count(s_corr_count), .uncorr_count(s_uncorr_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word; returns 1ns after the accepting edge with in_valid dropped.
    task automatic send_one(input logic [11:0] cw);
        int t;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_codeword = cw;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 20);
        if (!in_ready) check_val("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stream_words(input logic [11:0] w [8], input int n);
        int t;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_codeword = w[i];
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 20);
            if (!in_ready) check_val("stream_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        if (!out_valid) check_val("out_timeout", 0, 1);
    endtask

    logic [11:0] bw [4] = '{12'h301, 12'h4AA, 12'h3FF, 12'h4A2};
    logic [7:0]  bd [4] = '{8'h01, 8'hAA, 8'hFF, 8'hAA};
    logic        bc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [11:0] sw [8] = '{12'h4A2, 12'hB01, 12'h4A2, 12'hB01, 12'h4A2, 12'h000, 12'h000, 12'h000};
    logic [7:0]  got_d [8];
    logic        got_c [8];
    int          idx, acc, nout;
    logic        took;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b1; clear_counts = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_corr_count", corr_count, 0);
        rst_n = 1'b1;
        #1 check_val("rst_rel_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check_val("first_edge_in_ready", in_ready, 1);

        // clean words back to back, latency 2
        @(posedge clk); #1;
        in_valid = 1'b1; in_codeword = 12'h301;
        @(negedge clk); check_val("clean_accept", in_ready, 1);
        @(posedge clk); #1; in_codeword = 12'h4AA;
        @(negedge clk); check_val("clean_lat_vld0", out_valid, 0);
        @(posedge clk); #1; in_codeword = 12'h3FF;
        @(negedge clk);
        check_val("clean_vld_w0", out_valid, 1);
        check_val("clean_data_w0", out_data, 8'h01);
        check_val("clean_syn_w0", out_syndrome, 0);
        check_val("clean_flags_w0", {out_corrected, out_uncorrectable}, 0);
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        check_val("clean_data_w1", out_data, 8'hAA);
        check_val("clean_syn_w1", out_syndrome, 0);
        @(posedge clk);
        @(negedge clk);
        check_val("clean_data_w2", out_data, 8'hFF);
        check_val("clean_flags_w2", {out_corrected, out_uncorrectable}, 0);
        @(posedge clk);
        @(negedge clk);
        check_val("clean_drained", out_valid, 0);
        check_val("clean_corr_cnt", corr_count, 0);
        check_val("clean_uncorr_cnt", uncorr_count, 0);

        // data-bit error d3
        send_one(12'h4A2); wait_out();
        check_val("d3_syn", out_syndrome, 4'd7);
        check_val("d3_data", out_data, 8'hAA);
        check_val("d3_corr", out_corrected, 1);
        check_val("d3_uncorr", out_uncorrectable, 0);
        check_val("d3_corr_cnt", corr_count, 1);

        // check-bit error p3
        send_one(12'hB01); wait_out();
        check_val("p3_syn", out_syndrome, 4'd8);
        check_val("p3_data", out_data, 8'h01);
        check_val("p3_corr", out_corrected, 1);
        check_val("p3_corr_cnt", corr_count, 2);

        // double error aliasing to unmappable syndrome
        send_one(12'h319); wait_out();
        check_val("unc_syn", out_syndrome, 4'd14);
        check_val("unc_flag", out_uncorrectable, 1);
        check_val("unc_corr", out_corrected, 0);
        check_val("unc_data", out_data, 8'h19);
        check_val("unc_cnt", uncorr_count, 1);
        check_val("unc_corr_cnt", corr_count, 2);

        // clear, then saturate the 2-bit counter
        @(posedge clk); #1; clear_counts = 1'b1;
        @(posedge clk); #1; clear_counts = 1'b0;
        @(negedge clk);
        check_val("clr_corr_cnt", corr_count, 0);
        check_val("clr_uncorr_cnt", uncorr_count, 0);
        check_val("clr_sat_cnt", s_corr_count, 0);
        stream_words(sw, 5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("sat_cnt2", s_corr_count, 2'd3);
        check_val("sat_cnt16", corr_count, 5);
        check_val("sat_uncorr2", s_uncorr_count, 0);

        // clear coincides with a corrected word loading into S2
        send_one(12'h4A2);
        clear_counts = 1'b1;
        @(posedge clk); #1; clear_counts = 1'b0;
        @(negedge clk);
        check_val("clrwin_vld", out_valid, 1);
        check_val("clrwin_corr", out_corrected, 1);
        check_val("clrwin_cnt16", corr_count, 0);
        check_val("clrwin_cnt2", s_corr_count, 0);

        // backpressure: 4 words, out_ready low for the first 5 cycles
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0; in_valid = 1'b1; in_codeword = bw[0];
        idx = 0; acc = 0; nout = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            if (out_valid && out_ready) begin
                if (nout < 8) begin
                    got_d[nout] = out_data;
                    got_c[nout] = out_corrected;
                end
                nout++;
            end
            if (cyc >= 2 && cyc <= 4) begin
                check_val("bp_stall_vld", out_valid, 1);
                check_val("bp_stall_data", out_data, 8'h01);
                check_val("bp_stall_syn", out_syndrome, 0);
            end
            if (cyc == 4) begin
                check_val("bp_accepts", acc, 2);
                check_val("bp_in_ready", in_ready, 0);
            end
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (idx < 4) in_codeword = bw[idx];
                else         in_valid = 1'b0;
            end
            if (cyc == 4) out_ready = 1'b1;
            if (idx == 4 && nout == 4) break;
        end
        repeat (3) begin
            @(negedge clk);
            if (out_valid) nout++;
        end
        check_val("bp_count", nout, 4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("bp_data%0d", i), got_d[i], bd[i]);
            check_val($sformatf("bp_corr%0d", i), got_c[i], bc[i]);
        end

        // asynchronous reset mid-stream
        @(posedge clk); #1;
        in_valid = 1'b1; in_codeword = 12'h301;
        @(posedge clk); #1;
        @(posedge clk); #2;
        check_val("pre_rst_vld", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_vld", out_valid, 0);
        check_val("async_rst_in_ready", in_ready, 0);
        check_val("async_rst_cnt", corr_count, 0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1 check_val("post_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check_val("post_rst_vld", out_valid, 0);
        send_one(12'h3FF); wait_out();
        check_val("post_rst_data", out_data, 8'hFF);
        check_val("post_rst_syn", out_syndrome, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/hamming_dec_12_8.md
Name: hamming_dec_12_8

Overview:
- Pipelined single-error-correcting decoder for the team's 12-bit Hamming(12,8) codeword.
- Codeword layout is [11:0] = {p3,p2,p1,p0,d7..d0}.
  - p0 = d0^d1^d3^d4^d6
  - p1 = d0^d2^d3^d5^d6
  - p2 = d1^d2^d3^d7
  - p3 = d4^d5^d6^d7
- Sits on the receive side of the link, consuming codewords from the matching encoder.
- Returns corrected bytes with per-word status and saturating error counters over a valid/ready stream.

Parameters:
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  codeword valid
- in_ready  output  1  decoder can accept a codeword
- in_codeword  input  12  received codeword {p3,p2,p1,p0,d7..d0}
- out_valid  output  1  decoded result valid
- out_ready  input  1  downstream accepts result
- out_data  output  8  corrected data byte
- out_syndrome  output  4  syndrome {s3,s2,s1,s0}
- out_corrected  output  1  single-bit error corrected (data or check bit)
- out_uncorrectable  output  1  syndrome not mappable to a bit position
- clear_counts  input  1  synchronous counter clear
- corr_count  output  CNT_WIDTH  words with out_corrected set, saturating
- uncorr_count  output  CNT_WIDTH  words with out_uncorrectable set, saturating

Behaviour:
- Reset is asynchronous and active-low on rst_n. While rst_n is low, every register and output is 0 and in_ready is 0.
  - Pipeline valid bits clear even if a word is mid-flight; that word is dropped.
  - in_ready is 1 from the first clk edge after rst_n deasserts.
- The pipeline has 2 stages, S1 and S2, each with its own valid bit.
  - S1 registers the codeword and the syndrome. si = recomputed pi XOR received pi.
  - S2 registers the corrected data and status. S2 drives the out_* ports.
- Handshake:
  - adv2 = !s2_valid | out_ready
  - adv1 = !s1_valid | adv2
  - in_ready = adv1
  - A transfer occurs when valid & ready are both high.
  - out_* and out_valid hold stable while out_valid=1 and out_ready=0.
- Latency and throughput: accept at cycle N gives out_valid at N+2 when out_ready stays high. Throughput is one word per cycle; no bubbles are inserted.
- Syndrome decode is registered into S2:
  - 0: no error; data = received data.
  - 3, 5, 6, 7, 9, 10, 11, 12: flip d0, d1, d2, d3, d4, d5, d6, d7 respectively; out_corrected=1.
  - 1, 2, 4, 8: error in p0, p1, p2, p3; data unchanged; out_corrected=1.
  - 13, 14, 15: out_uncorrectable=1, out_corrected=0; data passed raw, uncorrected.
  - Double errors that alias to a legal syndrome are miscorrected. This is a known limit of the code without overall parity.
- out_corrected and out_uncorrectable are mutually exclusive.
- Counters:
  - A counter increments by 1 when a word is loaded into S2 with the matching flag.
  - Counters saturate at all-ones and never wrap.
  - If clear_counts and an increment occur in the same cycle, clear wins and the counter becomes 0.
- Simultaneous S2 drain and S1 refill in one cycle is legal and must not lose or duplicate words.

Test Plan:
- Clean words:
  - Stimulus: 0x301, 0x4AA, 0x3FF back-to-back, out_ready=1.
  - Required: out_data 0x01, 0xAA, 0xFF on consecutive cycles starting 2 cycles after the first accept; syndrome 0; both flags 0; counters 0.
- Data-bit error:
  - Stimulus: 0x4A2 (0x4AA with d3 flipped).
  - Required: syndrome 7, out_data 0xAA, out_corrected=1, corr_count=1.
- Check-bit error:
  - Stimulus: 0xB01 (0x301 with p3 flipped).
  - Required: syndrome 8, out_data 0x01, out_corrected=1.
- Uncorrectable:
  - Stimulus: 0x319 (0x301 with d3 and d4 flipped).
  - Required: syndrome 14, out_uncorrectable=1, out_data 0x19, uncorr_count=1.
- Backpressure:
  - Stimulus: stream 4 words with out_ready=0 for 5 cycles, then 1.
  - Required: in_ready drops after 2 accepts; out_* stable while stalled; all 4 words emerge in order with no loss or duplication.
- Counter edge cases:
  - Stimulus: CNT_WIDTH=2, send 5 corrected words.
  - Required: corr_count saturates at 3.
  - Stimulus: clear_counts in the same cycle as a corrected word loads into S2.
  - Required: corr_count=0.
  - Stimulus: assert rst_n low mid-stream.
  - Required: out_valid=0 immediately (asynchronously).
